// File: rtl/clk_div_monitor.sv
// Divided-clock health monitor: syncs clk_div_in, strobes its edges,
// measures rise-to-rise period and tracks lock / loss-of-lock events.
module clk_div_monitor #(
    parameter int EXP_PERIOD = 8,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_div_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault_pulse,
    output logic [7:0]       fault_count
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             fault_q, fault_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic [7:0]       fcnt_inc;
    logic             d_rise, d_fall, good_per, timeout;

    assign d_rise   = s2_q & ~s3_q;
    assign d_fall   = ~s2_q & s3_q;
    assign timeout  = (cnt_q == TMO) & ~d_rise;
    assign good_per = (int'(cnt_q) + TOL >= EXP_PERIOD) &&
                      (int'(cnt_q) <= EXP_PERIOD + TOL);
    assign fcnt_inc = (fcnt_q == 8'hFF) ? fcnt_q : fcnt_q + 8'd1;

    // Counter saturates so a stopped clock leaves cnt parked at TIMEOUT.
    assign cnt_d = d_rise ? CNT_W'(1) :
                   (cnt_q == TMO) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = period_q;
        pv_d     = pv_q;
        locked_d = locked_q;
        fault_d  = 1'b0;
        fcnt_d   = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (d_rise) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (d_rise) begin
                    period_d = cnt_q;
                    pv_d     = 1'b1;
                    if (!good_per) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                        if (good_q == LOCK_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    state_d  = IDLE;
                    pv_d     = 1'b0;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            LOCKED: begin
                if (d_rise) begin
                    period_d = cnt_q;
                    if (!good_per) begin
                        state_d  = MEASURE;
                        good_d   = '0;
                        locked_d = 1'b0;
                        fault_d  = 1'b1;
                        fcnt_d   = fcnt_inc;
                    end
                end else if (timeout) begin
                    state_d  = IDLE;
                    pv_d     = 1'b0;
                    locked_d = 1'b0;
                    good_d   = '0;
                    fault_d  = 1'b1;
                    fcnt_d   = fcnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            good_q   <= '0;
            period_q <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            s1_q     <= clk_div_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            rise_q   <= d_rise;
            fall_q   <= d_fall;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign fault_pulse  = fault_q;
    assign fault_count  = fcnt_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: two instances (TOL=0, TOL=1)
// watch one random divided clock; an event-level model predicts outputs.
module tb_clk_div_monitor;
    localparam int EXP   = 8;
    localparam int LOCKN = 4;
    localparam int TMO   = 32;

    typedef struct {
        int cyc;
        bit r;
        bit f;
        bit flt;
        int per;
        bit pv;
        bit lk;
        int fc;
    } rec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       div   = 1'b0;
    logic       rise_w [2];
    logic       fall_w [2];
    logic       pv_w   [2];
    logic       lk_w   [2];
    logic       flt_w  [2];
    logic [5:0] per_w  [2];
    logic [7:0] fc_w   [2];

    int   cyc     = 0;
    bit   rst_smp = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;
    rec_t sbq [2][$];

    // Reference model: mode 0 idle, 1 measuring, 2 locked
    int m_mode [2];
    int m_gc   [2];
    int m_per  [2];
    int m_fc   [2];
    int m_lr   [2];
    bit m_pv   [2];
    bit m_lk   [2];
    bit lvl;
    bit pv_p   [2];
    bit lk_p   [2];

    always #5 clk = ~clk;

    clk_div_monitor #(.TOL(0)) u_dut0 (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .clk_div_in  (div),
        .rise_pulse  (rise_w[0]),
        .fall_pulse  (fall_w[0]),
        .period      (per_w[0]),
        .period_valid(pv_w[0]),
        .locked      (lk_w[0]),
        .fault_pulse (flt_w[0]),
        .fault_count (fc_w[0])
    );

    clk_div_monitor #(.TOL(1)) u_dut1 (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .clk_div_in  (div),
        .rise_pulse  (rise_w[1]),
        .fall_pulse  (fall_w[1]),
        .period      (per_w[1]),
        .period_valid(pv_w[1]),
        .locked      (lk_w[1]),
        .fault_pulse (flt_w[1]),
        .fault_count (fc_w[1])
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_gc[i]   = 0;
            m_per[i]  = 0;
            m_fc[i]   = 0;
            m_lr[i]   = 0;
            m_pv[i]   = 1'b0;
            m_lk[i]   = 1'b0;
        end
        lvl = 1'b0;
    endfunction

    // n is the clk edge at which the new input level is first sampled;
    // everything it causes shows up on the outputs after edge n+2.
    function automatic void model_edge(int i, int n, bit rise, bit fall);
        rec_t r;
        bit   flt = 1'b0;
        bit   vis = 1'b0;
        bit   good;
        int   p;
        if (rise) begin
            if (m_mode[i] == 0) begin
                m_mode[i] = 1;
                m_gc[i]   = 0;
            end else begin
                p        = n - m_lr[i];
                good     = (p - EXP <= i) && (EXP - p <= i);
                m_per[i] = p;
                m_pv[i]  = 1'b1;
                if (m_mode[i] == 1) begin
                    m_gc[i] = good ? m_gc[i] + 1 : 0;
                    if (m_gc[i] == LOCKN) begin
                        m_mode[i] = 2;
                        m_lk[i]   = 1'b1;
                    end
                end else if (!good) begin
                    m_mode[i] = 1;
                    m_gc[i]   = 0;
                    m_lk[i]   = 1'b0;
                    flt       = 1'b1;
                    m_fc[i]   = (m_fc[i] < 255) ? m_fc[i] + 1 : 255;
                end
            end
            m_lr[i] = n;
            vis     = 1'b1;
        end else if (m_mode[i] != 0 && n - m_lr[i] == TMO) begin
            vis = m_pv[i] | m_lk[i];
            if (m_mode[i] == 2) begin
                flt     = 1'b1;
                m_fc[i] = (m_fc[i] < 255) ? m_fc[i] + 1 : 255;
            end
            m_mode[i] = 0;
            m_gc[i]   = 0;
            m_pv[i]   = 1'b0;
            m_lk[i]   = 1'b0;
        end
        if (vis || fall) begin
            r.cyc = n + 2;
            r.r   = rise;
            r.f   = fall;
            r.flt = flt;
            r.per = m_per[i];
            r.pv  = m_pv[i];
            r.lk  = m_lk[i];
            r.fc  = m_fc[i];
            sbq[i].push_back(r);
        end
    endfunction

    task automatic step(input bit v);
        bit rise;
        bit fall;
        @(posedge clk);
        #2;
        div  = v;
        rise = v & ~lvl;
        fall = ~v & lvl;
        lvl  = v;
        for (int i = 0; i < 2; i++) model_edge(i, cyc + 1, rise, fall);
    endtask

    task automatic per_hl(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        div   = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        rst_smp = rst_n;
        cyc     = cyc + 1;
    end

    initial forever begin
        bit   evt;
        rec_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_smp) begin
                n_chk++;
                if (rise_w[i] || fall_w[i] || pv_w[i] || lk_w[i] ||
                    flt_w[i] || per_w[i] != 6'd0 || fc_w[i] != 8'd0) begin
                    n_err++;
                    $display("FAIL reset[%0d] cyc %0d: got r%0b f%0b pv%0b lk%0b flt%0b per%0d fc%0d, want all 0",
                             i, cyc, rise_w[i], fall_w[i], pv_w[i], lk_w[i],
                             flt_w[i], per_w[i], fc_w[i]);
                end
                sbq[i].delete();
                pv_p[i] = 1'b0;
                lk_p[i] = 1'b0;
            end else begin
                evt = rise_w[i] | fall_w[i] | flt_w[i] |
                      (pv_p[i] & ~pv_w[i]) | (lk_p[i] & ~lk_w[i]);
                while (sbq[i].size() > 0 && sbq[i][0].cyc < cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL missing[%0d]: event due cyc %0d absent",
                             i, sbq[i][0].cyc);
                    void'(sbq[i].pop_front());
                end
                if (evt) begin
                    n_chk++;
                    if (sbq[i].size() == 0 || sbq[i][0].cyc != cyc) begin
                        n_err++;
                        $display("FAIL unexpected[%0d] cyc %0d: r%0b f%0b flt%0b per%0d pv%0b lk%0b fc%0d, want no event",
                                 i, cyc, rise_w[i], fall_w[i], flt_w[i],
                                 per_w[i], pv_w[i], lk_w[i], fc_w[i]);
                    end else begin
                        e = sbq[i].pop_front();
                        if (rise_w[i] != e.r || fall_w[i] != e.f ||
                            flt_w[i] != e.flt || int'(per_w[i]) != e.per ||
                            pv_w[i] != e.pv || lk_w[i] != e.lk ||
                            int'(fc_w[i]) != e.fc) begin
                            n_err++;
                            $display("FAIL event[%0d] cyc %0d: got r%0b f%0b flt%0b per%0d pv%0b lk%0b fc%0d, want r%0b f%0b flt%0b per%0d pv%0b lk%0b fc%0d",
                                     i, cyc, rise_w[i], fall_w[i], flt_w[i],
                                     per_w[i], pv_w[i], lk_w[i], fc_w[i],
                                     e.r, e.f, e.flt, e.per, e.pv, e.lk, e.fc);
                        end
                    end
                end else if (sbq[i].size() > 0 && sbq[i][0].cyc == cyc) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL missing[%0d]: event due cyc %0d absent",
                             i, cyc);
                    void'(sbq[i].pop_front());
                end
                pv_p[i] = pv_w[i];
                lk_p[i] = lk_w[i];
            end
        end
    end

    initial begin
        int r;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // Lock acquisition
        repeat (8) per_hl(4, 4);
        // Short period while locked, then relock
        per_hl(2, 4);
        repeat (6) per_hl(4, 4);
        // Tolerance: 9 then 10
        per_hl(5, 4);
        per_hl(5, 5);
        repeat (6) per_hl(4, 4);
        // Period equal to the timeout: rise wins, evaluated as bad
        per_hl(16, 16);
        repeat (6) per_hl(4, 4);
        // Reset while locked with three faults logged
        do_reset();
        repeat (6) per_hl(4, 4);
        // Stopped clock, then long idle
        repeat (70) step(1'b0);
        // Random mix of good, near-miss and wild periods
        repeat (150) begin
            r = $urandom_range(0, 9);
            if (r < 4) per_hl(4, 4);
            else if (r < 8) per_hl(4, $urandom_range(2, 7));
            else per_hl($urandom_range(1, 20), $urandom_range(1, 20));
        end
        // Saturate the fault counter
        repeat (260) begin
            per_hl(3, 3);
            repeat (4) per_hl(4, 4);
        end
        repeat (40) step(1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (sbq[i].size() != 0) begin
                n_err++;
                $display("FAIL drain[%0d]: %0d events pending, want 0",
                         i, sbq[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
